decision_trail: RTL and testbench
=================================

DECISION_TRAIL -- requirements
Module: decision_trail

Interface
REQ-001 Parameter WIDTH, default 4; literal code width, MSB = negation flag, low WIDTH-1 bits = variable index.
REQ-002 Parameter MAX_LITERALS, default 8; length of assignment vectors. Index 0 is reserved as "no literal".
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 decide_req  in  1  request one decision.
REQ-006 imply_valid  in  1  unit-implication strobe.
REQ-007 imply_lit  in  WIDTH  implied literal, in clause encoding.
REQ-008 conflict  in  1  conflict detected by the clause-update path.
REQ-009 ready  out  1  high in IDLE; commands are accepted only when ready is high.
REQ-010 literal_assigned  out  MAX_LITERALS  per-variable assigned flag.
REQ-011 literal_bool  out  MAX_LITERALS  per-variable value; meaningful only where assigned.
REQ-012 trail_depth  out  $clog2(MAX_LITERALS)+1  number of trail entries.
REQ-013 sat  out  1  all of bits [MAX_LITERALS-1:1] of literal_assigned are 1.
REQ-014 unsat  out  1  backtrack found no unflipped decision.
REQ-015 imply_err  out  1  one-cycle pulse when an implication contradicts an existing assignment.

Function
REQ-016 States: IDLE, BACKTRACK, UNSAT.
REQ-017 Trail is a MAX_LITERALS-1 deep LIFO; each entry holds {var index, is_decision, flipped}.
REQ-018 Command priority in IDLE: conflict > imply_valid > decide_req; lower-priority commands in the same cycle are dropped.
REQ-019 Decide, normal case:
  - Picks the lowest unassigned index >= 1.
  - Sets assigned=1 and bool=1 for that index.
  - Pushes {idx, 1, 0}.
  - Outputs update on the next edge, giving 1-cycle latency.
REQ-020 Decide when sat=1 is ignored, with no state change.
REQ-021 Imply on an unassigned index:
  - Sets assigned=1 and bool=~imply_lit[WIDTH-1].
  - Pushes {idx, 0, 0}.
  - 1-cycle latency.
REQ-022 Imply with index 0, or on an index already assigned to the same value, is ignored.
REQ-023 Imply on an index assigned to the opposite value changes no state and pulses imply_err on the next cycle.
REQ-024 Conflict in IDLE moves to BACKTRACK; ready falls on the next cycle.
REQ-025 BACKTRACK pops at most one entry per cycle; the top entry is handled as follows:
  - Implied entry, or decision with flipped=1: pop it and clear its assigned and bool bits.
  - Decision with flipped=0: set bool=0 and flipped=1, keep the entry, return to IDLE.
REQ-026 BACKTRACK with an empty trail moves to UNSAT.
REQ-027 UNSAT holds unsat=1, ready=0 and all vectors frozen until reset.
REQ-028 Commands arriving while ready=0 are ignored.
REQ-029 trail_depth saturates at MAX_LITERALS-1; a push into a full trail cannot occur, because every index is then assigned.

Reset
REQ-030 While rst_n=0 at an edge:
  - State goes to IDLE and the trail empties.
  - literal_assigned=0, literal_bool=0, trail_depth=0.
  - sat=0, unsat=0, imply_err=0, ready=1 on the following cycle.
REQ-031 Reset takes effect mid-BACKTRACK or in UNSAT with the same result; no partial pop completes.

Configuration
REQ-032 Macro DECISION_TRAIL_STATS_EN defined adds two outputs, each a 16-bit saturating counter that clears on reset:
  - decision_count: +1 per accepted decide.
  - backtrack_count: +1 per flip.
REQ-033 Macro undefined: neither port nor either counter exists; all other behaviour is identical.

Structure
REQ-034 Shared package dpll_pkg holds:
  - WIDTH and MAX_LITERALS defaults.
  - Literal field constants: NEG_BIT = WIDTH-1, index slice.
  - Trail entry struct and state enum.
REQ-035 One sub-module, free_lit_finder: combinational priority encoder returning the lowest unassigned index >= 1 and a found flag.

Verification
REQ-036 Defaults, after reset: decide -> assigned=8'b0000_0010, bool=8'b0000_0010, depth=1.
REQ-037 Then imply_lit=4'b1110 -> assigned=8'b0100_0010, bool bit6=0, depth=2.
  - Then imply_lit=4'b0110 -> imply_err pulse, vectors unchanged.
REQ-038 Decide var1, imply var3, conflict -> after backtrack: assigned=8'b0000_0010, bool bit1=0, depth=1, ready=1.
  - Ready returns 3 cycles after conflict.
REQ-039 Repeat the conflict in REQ-038 -> trail empties -> unsat=1, ready=0.
  - decide_req is then ignored.
REQ-040 Seven decides -> assigned=8'b1111_1110, sat=1.
  - An eighth decide changes nothing.
  - Same-cycle conflict+decide -> only the backtrack runs.
REQ-041 rst_n=0 asserted mid-BACKTRACK -> all outputs return to reset values next cycle.
  - With DECISION_TRAIL_STATS_EN defined, counts return to 0.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared types and constants for the DPLL decision trail: literal encoding,
// trail entry layout and the controller state enum.
package dpll_pkg;

    localparam int DEF_WIDTH        = 4;
    localparam int DEF_MAX_LITERALS = 8;

    // Literal code: MSB is the negation flag, the bits below it are the variable index
    localparam int NEG_BIT = DEF_WIDTH - 1;
    localparam int IDX_MSB = DEF_WIDTH - 2;
    localparam int IDX_LSB = 0;

    typedef struct packed {
        logic [IDX_MSB:IDX_LSB] idx;
        logic                   is_dec;
        logic                   flipped;
    } trail_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BACKTRACK = 2'd1,
        ST_UNSAT     = 2'd2
    } state_t;

endpackage

// File: rtl/decision_trail_free_lit_finder.sv
// Combinational priority encoder: lowest unassigned variable index >= 1.
module free_lit_finder #(
    parameter int MAX_LITERALS = 8,
    parameter int IDX_W        = 3
) (
    input  logic [MAX_LITERALS-1:0] assigned_i,
    output logic [IDX_W-1:0]        idx_o,
    output logic                    found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Scan downwards so the lowest free index is the last one written
        for (int i = MAX_LITERALS - 1; i >= 1; i--) begin
            if (!assigned_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decision_trail.sv
// DPLL decision trail: decide/imply/backtrack controller over a LIFO trail.
// Define DECISION_TRAIL_STATS_EN to add decision_count/backtrack_count outputs.
module decision_trail
    import dpll_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int MAX_LITERALS = DEF_MAX_LITERALS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            decide_req,
    input  logic                            imply_valid,
    input  logic [WIDTH-1:0]                imply_lit,
    input  logic                            conflict,
    output logic                            ready,
    output logic [MAX_LITERALS-1:0]         literal_assigned,
    output logic [MAX_LITERALS-1:0]         literal_bool,
    output logic [$clog2(MAX_LITERALS):0]   trail_depth,
    output logic                            sat,
    output logic                            unsat,
    output logic                            imply_err
`ifdef DECISION_TRAIL_STATS_EN
    ,
    output logic [15:0]                     decision_count,
    output logic [15:0]                     backtrack_count
`endif
);

    localparam int DW    = $clog2(MAX_LITERALS) + 1;
    localparam int DEPTH = MAX_LITERALS - 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int IW    = WIDTH - 1;

    state_t                  state_q, state_d;
    logic [MAX_LITERALS-1:0] asg_q, asg_d, bool_q, bool_d;
    logic [DW-1:0]           depth_q, depth_d;
    logic                    err_q, err_d;
    trail_entry_t            trail_q [DEPTH];
    trail_entry_t            trail_d [DEPTH];

    logic [IW-1:0]           free_idx;
    logic                    free_found;
    logic [IW-1:0]           imp_idx;
    logic                    imp_val;
    logic [PW-1:0]           top_ptr, push_ptr;
    trail_entry_t            top;
    logic                    do_decide, do_flip;

    free_lit_finder #(
        .MAX_LITERALS (MAX_LITERALS),
        .IDX_W        (IW)
    ) u_finder (
        .assigned_i (asg_q),
        .idx_o      (free_idx),
        .found_o    (free_found)
    );

    assign imp_idx   = imply_lit[IDX_MSB:IDX_LSB];
    assign imp_val   = ~imply_lit[NEG_BIT];
    assign top_ptr   = PW'(depth_q - DW'(1));
    assign push_ptr  = PW'(depth_q);
    assign top       = trail_q[top_ptr];
    assign sat       = &asg_q[MAX_LITERALS-1:1];
    // Decide only fires when no higher-priority command claims the cycle
    assign do_decide = (state_q == ST_IDLE) && !conflict && !imply_valid &&
                       decide_req && !sat && free_found && (depth_q < DW'(DEPTH));
    assign do_flip   = (state_q == ST_BACKTRACK) && (depth_q != '0) &&
                       top.is_dec && !top.flipped;

    always_comb begin
        state_d = state_q;
        asg_d   = asg_q;
        bool_d  = bool_q;
        depth_d = depth_q;
        err_d   = 1'b0;
        trail_d = trail_q;
        case (state_q)
            ST_IDLE: begin
                if (conflict) begin
                    state_d = ST_BACKTRACK;
                end else if (imply_valid) begin
                    if (imp_idx != '0) begin
                        if (!asg_q[imp_idx]) begin
                            if (depth_q < DW'(DEPTH)) begin
                                asg_d[imp_idx]    = 1'b1;
                                bool_d[imp_idx]   = imp_val;
                                trail_d[push_ptr] = '{idx: imp_idx, is_dec: 1'b0, flipped: 1'b0};
                                depth_d           = depth_q + DW'(1);
                            end
                        end else if (bool_q[imp_idx] != imp_val) begin
                            err_d = 1'b1;
                        end
                    end
                end else if (do_decide) begin
                    asg_d[free_idx]   = 1'b1;
                    bool_d[free_idx]  = 1'b1;
                    trail_d[push_ptr] = '{idx: free_idx, is_dec: 1'b1, flipped: 1'b0};
                    depth_d           = depth_q + DW'(1);
                end
            end
            ST_BACKTRACK: begin
                if (depth_q == '0) begin
                    state_d = ST_UNSAT;
                end else if (do_flip) begin
                    bool_d[top.idx]          = 1'b0;
                    trail_d[top_ptr].flipped = 1'b1;
                    state_d                  = ST_IDLE;
                end else begin
                    asg_d[top.idx]  = 1'b0;
                    bool_d[top.idx] = 1'b0;
                    depth_d         = depth_q - DW'(1);
                end
            end
            ST_UNSAT: begin
                state_d = ST_UNSAT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            asg_q   <= '0;
            bool_q  <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            asg_q   <= asg_d;
            bool_q  <= bool_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Entry contents are only meaningful below depth_q, so they need no reset
    always_ff @(posedge clk) begin
        trail_q <= trail_d;
    end

`ifdef DECISION_TRAIL_STATS_EN
    logic [15:0] dec_cnt_q, bt_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_cnt_q <= '0;
            bt_cnt_q  <= '0;
        end else begin
            if (do_decide && (dec_cnt_q != 16'hFFFF)) dec_cnt_q <= dec_cnt_q + 16'd1;
            if (do_flip && (bt_cnt_q != 16'hFFFF))    bt_cnt_q  <= bt_cnt_q + 16'd1;
        end
    end

    assign decision_count  = dec_cnt_q;
    assign backtrack_count = bt_cnt_q;
`endif

    assign ready            = (state_q == ST_IDLE);
    assign unsat            = (state_q == ST_UNSAT);
    assign literal_assigned = asg_q;
    assign literal_bool     = bool_q;
    assign trail_depth      = depth_q;
    assign imply_err        = err_q;

endmodule

// File: tb/tb_decision_trail.sv
// Directed scoreboard bench for decision_trail at default parameters.
module tb_decision_trail;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       decide_req = 1'b0;
    logic       imply_valid = 1'b0;
    logic [3:0] imply_lit = 4'b0000;
    logic       conflict = 1'b0;
    logic       ready, sat, unsat, imply_err;
    logic [7:0] literal_assigned, literal_bool;
    logic [3:0] trail_depth;
`ifdef DECISION_TRAIL_STATS_EN
    logic [15:0] decision_count, backtrack_count;
`endif

    typedef struct packed {
        logic [7:0] asg;
        logic [7:0] bl;
        logic [3:0] depth;
        logic       rdy;
        logic       sat;
        logic       unsat;
        logic       err;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    decision_trail dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .decide_req       (decide_req),
        .imply_valid      (imply_valid),
        .imply_lit        (imply_lit),
        .conflict         (conflict),
        .ready            (ready),
        .literal_assigned (literal_assigned),
        .literal_bool     (literal_bool),
        .trail_depth      (trail_depth),
        .sat              (sat),
        .unsat            (unsat),
        .imply_err        (imply_err)
`ifdef DECISION_TRAIL_STATS_EN
        ,
        .decision_count   (decision_count),
        .backtrack_count  (backtrack_count)
`endif
    );

    function automatic exp_t mk(logic [7:0] a, logic [7:0] b, logic [3:0] d,
                                logic r, logic s, logic u, logic e);
        exp_t x;
        x.asg = a; x.bl = b; x.depth = d; x.rdy = r; x.sat = s; x.unsat = u; x.err = e;
        return x;
    endfunction

    task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        chk(t, "assigned", {8'h00, literal_assigned}, {8'h00, e.asg});
        chk(t, "bool",     {8'h00, literal_bool},     {8'h00, e.bl});
        chk(t, "depth",    {12'h000, trail_depth},    {12'h000, e.depth});
        chk(t, "ready",    {15'h0, ready},            {15'h0, e.rdy});
        chk(t, "sat",      {15'h0, sat},              {15'h0, e.sat});
        chk(t, "unsat",    {15'h0, unsat},            {15'h0, e.unsat});
        chk(t, "imply_err",{15'h0, imply_err},        {15'h0, e.err});
    endtask

    // One clock: drive inputs, queue the expected post-edge outputs, compare after the edge
    task automatic step(input string tag, input logic rn, input logic d, input logic iv,
                        input logic [3:0] lit, input logic c, input exp_t e);
        rst_n       = rn;
        decide_req  = d;
        imply_valid = iv;
        imply_lit   = lit;
        conflict    = c;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        decide_req  = 1'b0;
        imply_valid = 1'b0;
        imply_lit   = 4'b0000;
        conflict    = 1'b0;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] m;
        #2;
        // Reset and basic decide/imply
        step("reset",      1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, mk(8'h00, 8'h00, 4'd0, 1, 0, 0, 0));
        step("decide1",    1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, mk(8'h02, 8'h02, 4'd1, 1, 0, 0, 0));
        step("imply_n6",   1'b1, 1'b0, 1'b1, 4'b1110, 1'b0, mk(8'h42, 8'h02, 4'd2, 1, 0, 0, 0));
        step("imply_p6",   1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, mk(8'h42, 8'h02, 4'd2, 1, 0, 0, 1));
        step("err_drop",   1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, mk(8'h42, 8'h02, 4'd2, 1, 0, 0, 0));
        step("imply_same", 1'b1, 1'b0, 1'b1, 4'b1110, 1'b0, mk(8'h42, 8'h02, 4'd2, 1, 0, 0, 0));
        step("imply_idx0", 1'b1, 1'b0, 1'b1, 4'b1000, 1'b0, mk(8'h42, 8'h02, 4'd2, 1, 0, 0, 0));
        step("imply_pri",  1'b1, 1'b1, 1'b1, 4'b0101, 1'b0, mk(8'h62, 8'h22, 4'd3, 1, 0, 0, 0));

        // Conflict, backtrack with flip; decide during ready=0 is dropped
        step("reset2",     1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, mk(8'h00, 8'h00, 4'd0, 1, 0, 0, 0));
        step("dec_v1",     1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, mk(8'h02, 8'h02, 4'd1, 1, 0, 0, 0));
        step("imp_v3",     1'b1, 1'b0, 1'b1, 4'b0011, 1'b0, mk(8'h0A, 8'h0A, 4'd2, 1, 0, 0, 0));
        step("conflict1",  1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, mk(8'h0A, 8'h0A, 4'd2, 0, 0, 0, 0));
        step("bt_pop3",    1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, mk(8'h02, 8'h02, 4'd1, 0, 0, 0, 0));
        step("bt_flip1",   1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, mk(8'h02, 8'h00, 4'd1, 1, 0, 0, 0));

        // Second conflict empties the trail and lands in UNSAT
        step("conflict2",  1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, mk(8'h02, 8'h00, 4'd1, 0, 0, 0, 0));
        step("bt_pop1",    1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, mk(8'h00, 8'h00, 4'd0, 0, 0, 0, 0));
        step("to_unsat",   1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, mk(8'h00, 8'h00, 4'd0, 0, 0, 1, 0));
        step("unsat_dec",  1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, mk(8'h00, 8'h00, 4'd0, 0, 0, 1, 0));
        step("unsat_imp",  1'b1, 1'b0, 1'b1, 4'b0010, 1'b0, mk(8'h00, 8'h00, 4'd0, 0, 0, 1, 0));

        // Reset out of UNSAT, then fill every variable by decisions
        step("reset3",     1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, mk(8'h00, 8'h00, 4'd0, 1, 0, 0, 0));
        for (int i = 1; i <= 7; i++) begin
            m = (9'd1 << (i + 1)) - 9'd2;
            step($sformatf("fill%0d", i), 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0,
                 mk(m[7:0], m[7:0], 4'(i), 1, (i == 7), 0, 0));
        end
        step("dec_at_sat", 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, mk(8'hFE, 8'hFE, 4'd7, 1, 1, 0, 0));
        step("conf_dec",   1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, mk(8'hFE, 8'hFE, 4'd7, 0, 1, 0, 0));
        step("flip7",      1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, mk(8'hFE, 8'h7E, 4'd7, 1, 1, 0, 0));
`ifdef DECISION_TRAIL_STATS_EN
        chk("stats", "decision_count",  decision_count,  16'd7);
        chk("stats", "backtrack_count", backtrack_count, 16'd1);
`endif

        // Reset in the middle of a backtrack
        step("conflict3",  1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, mk(8'hFE, 8'h7E, 4'd7, 0, 1, 0, 0));
        step("bt_pop7",    1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, mk(8'h7E, 8'h7E, 4'd6, 0, 0, 0, 0));
        step("rst_mid_bt", 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, mk(8'h00, 8'h00, 4'd0, 1, 0, 0, 0));
`ifdef DECISION_TRAIL_STATS_EN
        chk("stats_rst", "decision_count",  decision_count,  16'd0);
        chk("stats_rst", "backtrack_count", backtrack_count, 16'd0);
`endif
        step("post_rst",   1'b1, 1'b0, 1'b1, 4'b1001, 1'b0, mk(8'h02, 8'h00, 4'd1, 1, 0, 0, 0));
        step("post_dec",   1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, mk(8'h06, 8'h04, 4'd2, 1, 0, 0, 0));

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
